// File: rtl/cr_core_pkg.sv
// Shared definitions for cr_core: opcode values, FSM states and instruction field positions.
package cr_core_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SHIFT  = 4'd5;
  localparam logic [3:0] OP_LOAD   = 4'd6;
  localparam logic [3:0] OP_STORE  = 4'd7;
  localparam logic [3:0] OP_MOVE   = 4'd8;
  localparam logic [3:0] OP_JUMP   = 4'd9;
  localparam logic [3:0] OP_LOADC  = 4'd10;
  localparam logic [3:0] OP_OUT    = 4'd11;
  localparam logic [3:0] OP_JUMPZ  = 4'd12;
  localparam logic [3:0] OP_LOADCH = 4'd13;
  localparam logic [3:0] OP_HALT   = 4'd14;
  localparam logic [3:0] OP_NOP    = 4'd15;

  localparam int OPC_LSB = 12;
  localparam int EH_LSB  = 10;
  localparam int EL_LSB  = 8;
  localparam int K_LSB   = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MEM    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/cr_alu.sv
// Combinational ALU for cr_core: ADD/SUB/AND/OR/XOR/SHIFT; any other opcode passes B through (used by MOVE).
module cr_alu
  import cr_core_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  shr_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  zero_o
);

  localparam logic [DATA_WIDTH-1:0] WIDTH_V = DATA_WIDTH'(DATA_WIDTH);

  always_comb begin
    res_o = b_i;
    case (op_i)
      OP_ADD: res_o = a_i + b_i;
      OP_SUB: res_o = a_i - b_i;
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_SHIFT: begin
        if (b_i >= WIDTH_V) res_o = '0;
        else if (shr_i)     res_o = a_i >> b_i;
        else                res_o = a_i << b_i;
      end
      default: ;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/cr_core.sv
// Multi-cycle 4-register CPU with req/ack instruction and data memory ports.
// Define CR_CORE_ZFLAG_EN to build the zero flag and a real JUMPZ; otherwise JUMPZ acts as NOP.
module cr_core
  import cr_core_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  output logic                       o_imem_req,
  output logic [INST_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                       i_imem_ack,
  input  logic [15:0]                i_imem_data,
  output logic                       o_dmem_req,
  output logic                       o_dmem_we,
  output logic [DATA_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                       i_dmem_ack,
  input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
  output logic [DATA_WIDTH-1:0]      o_out,
  output logic                       o_out_valid,
  output logic                       o_halted
);

  state_e                     state_q;
  logic [INST_ADDR_WIDTH-1:0] pc_q;
  logic [15:0]                ir_q;
  logic [DATA_WIDTH-1:0]      regs_q [4];
  logic                       imem_req_q, dmem_req_q, dmem_we_q, out_valid_q, halted_q;
  logic [DATA_ADDR_WIDTH-1:0] dmem_addr_q;
  logic [DATA_WIDTH-1:0]      dmem_wdata_q, out_q;
`ifdef CR_CORE_ZFLAG_EN
  logic                       z_q;
`endif

  logic [3:0]                 opc;
  logic [1:0]                 eh, el;
  logic [7:0]                 k;
  logic [DATA_WIDTH-1:0]      k_ext, alu_a_d, alu_b_d, alu_res;
  logic                       alu_zero;
  logic [INST_ADDR_WIDTH-1:0] pc_inc_d, jump_tgt;

  assign opc      = ir_q[OPC_LSB +: 4];
  assign eh       = ir_q[EH_LSB +: 2];
  assign el       = ir_q[EL_LSB +: 2];
  assign k        = ir_q[K_LSB +: 8];
  assign k_ext    = DATA_WIDTH'(k);
  assign pc_inc_d = pc_q + INST_ADDR_WIDTH'(1);
  assign jump_tgt = regs_q[0][INST_ADDR_WIDTH-1:0];

  // SHIFT operates on reg[eh] by k or rd; MOVE routes reg[el] through the ALU so Z is shared.
  always_comb begin
    alu_a_d = el[1] ? regs_q[1] : regs_q[0];
    alu_b_d = el[0] ? k_ext : regs_q[2];
    if (opc == OP_SHIFT) begin
      alu_a_d = regs_q[eh];
      alu_b_d = el[1] ? k_ext : regs_q[3];
    end else if (opc == OP_MOVE) begin
      alu_b_d = regs_q[el];
    end
  end

  cr_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i   (opc),
    .a_i    (alu_a_d),
    .b_i    (alu_b_d),
    .shr_i  (el[0]),
    .res_o  (alu_res),
    .zero_o (alu_zero)
  );

`ifndef CR_CORE_ZFLAG_EN
  logic zero_unused;
  assign zero_unused = alu_zero;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef CR_CORE_ZFLAG_EN
      z_q         <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        // Only the cycle after reset reaches FETCH with req low; every other entry arrives with req set.
        ST_FETCH: begin
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (i_imem_ack) begin
            ir_q       <= i_imem_data;
            imem_req_q <= 1'b0;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
          pc_q       <= pc_inc_d;
          case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_MOVE: begin
              regs_q[eh] <= alu_res;
`ifdef CR_CORE_ZFLAG_EN
              z_q        <= alu_zero;
`endif
            end
            OP_LOADC:  regs_q[eh] <= k_ext;
            OP_LOADCH: regs_q[eh][15:8] <= k;
            OP_LOAD, OP_STORE: begin
              state_q      <= ST_MEM;
              imem_req_q   <= 1'b0;
              pc_q         <= pc_q;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= (opc == OP_STORE);
              dmem_addr_q  <= k[DATA_ADDR_WIDTH-1:0];
              dmem_wdata_q <= regs_q[eh];
            end
            OP_JUMP: pc_q <= jump_tgt;
`ifdef CR_CORE_ZFLAG_EN
            OP_JUMPZ: if (z_q) pc_q <= jump_tgt;
`endif
            OP_OUT: begin
              out_q       <= regs_q[eh];
              out_valid_q <= 1'b1;
            end
            OP_HALT: begin
              state_q    <= ST_HALTED;
              imem_req_q <= 1'b0;
              pc_q       <= pc_q;
              halted_q   <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (i_dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (!dmem_we_q) regs_q[eh] <= i_dmem_rdata;
            pc_q       <= pc_inc_d;
            imem_req_q <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_HALTED: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign o_imem_req   = imem_req_q;
  assign o_imem_addr  = pc_q;
  assign o_dmem_req   = dmem_req_q;
  assign o_dmem_we    = dmem_we_q;
  assign o_dmem_addr  = dmem_addr_q;
  assign o_dmem_wdata = dmem_wdata_q;
  assign o_out        = out_q;
  assign o_out_valid  = out_valid_q;
  assign o_halted     = halted_q;

endmodule

// File: tb/tb_cr_core.sv
// Self-checking bench for cr_core (DATA_WIDTH=32): directed programs plus random programs,
// compared against an instruction-level interpreter of the ISA.
module tb_cr_core;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          o_imem_req, i_imem_ack;
  logic [7:0]    o_imem_addr;
  logic [15:0]   i_imem_data;
  logic          o_dmem_req, o_dmem_we, i_dmem_ack;
  logic [7:0]    o_dmem_addr;
  logic [DW-1:0] o_dmem_wdata, i_dmem_rdata, o_out;
  logic          o_out_valid, o_halted;

  always #5 clk = ~clk;

  cr_core #(.DATA_WIDTH(DW), .INST_ADDR_WIDTH(8), .DATA_ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_out(o_out), .o_out_valid(o_out_valid), .o_halted(o_halted)
  );

  logic [15:0]   imem [256];
  logic [DW-1:0] dmem [256];
  logic [DW-1:0] mdm  [256];
  int            maxd = 0;
  bit            iblock = 0, force_iack = 0, noise = 0, m_halted = 0;
  logic [7:0]    got_fetch [$], exp_fetch [$];
  logic [DW-1:0] got_out [$], exp_out [$];
  int            n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] enc(input int op, input int eh, input int el, input int k);
    return {op[3:0], eh[1:0], el[1:0], k[7:0]};
  endfunction

  function automatic logic [DW-1:0] out_at(input int i);
    if (i < got_out.size()) return got_out[i];
    return 'x;
  endfunction

  function automatic logic [7:0] fetch_at(input int i);
    if (i < got_fetch.size()) return got_fetch[i];
    return 'x;
  endfunction

  // Instruction memory: random 0..maxd wait states, optional spurious acks while req is low.
  initial begin
    bit         pend;
    int         cnt;
    logic [7:0] a_s;
    pend = 0; cnt = 0; a_s = '0;
    i_imem_ack = 1'b0; i_imem_data = '0;
    forever begin
      @(negedge clk);
      i_imem_ack = 1'b0;
      if (!o_imem_req) pend = 0;
      if (force_iack) begin
        i_imem_ack = 1'b1; i_imem_data = 16'hB000;
      end else if (o_imem_req && !iblock) begin
        if (!pend) begin
          pend = 1; cnt = $urandom_range(maxd, 0); a_s = o_imem_addr;
        end else check("imem_addr_stable", o_imem_addr, a_s);
        if (cnt == 0) begin
          i_imem_ack = 1'b1; i_imem_data = imem[o_imem_addr]; pend = 0;
          got_fetch.push_back(o_imem_addr);
        end else cnt--;
      end else if (!o_imem_req && noise && $urandom_range(3, 0) == 0) begin
        i_imem_ack = 1'b1; i_imem_data = 16'(($urandom));
      end
    end
  end

  // Data memory: same wait-state model; checks address/we/wdata hold while waiting.
  initial begin
    bit            pend, we_s;
    int            cnt;
    logic [7:0]    a_s;
    logic [DW-1:0] wd_s;
    pend = 0; cnt = 0; a_s = '0; we_s = 0; wd_s = '0;
    i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    forever begin
      @(negedge clk);
      i_dmem_ack = 1'b0;
      if (!o_dmem_req) pend = 0;
      if (o_dmem_req) begin
        if (!pend) begin
          pend = 1; cnt = $urandom_range(maxd, 0);
          a_s = o_dmem_addr; we_s = o_dmem_we; wd_s = o_dmem_wdata;
        end else begin
          check("dmem_addr_stable", o_dmem_addr, a_s);
          check("dmem_we_stable", o_dmem_we, we_s);
          check("dmem_wdata_stable", o_dmem_wdata, wd_s);
        end
        if (cnt == 0) begin
          i_dmem_ack = 1'b1; pend = 0;
          if (o_dmem_we) dmem[o_dmem_addr] = o_dmem_wdata;
          else           i_dmem_rdata = dmem[o_dmem_addr];
        end else cnt--;
      end else if (noise && $urandom_range(3, 0) == 0) begin
        i_dmem_ack = 1'b1; i_dmem_rdata = $urandom;
      end
    end
  end

  // ISA interpreter: one loop iteration per instruction, producing the expected fetch and OUT traces.
  task automatic run_model(input int max_instr);
    logic [DW-1:0] r [4];
    logic [DW-1:0] a, b, res, amt;
    logic [7:0]    pc, k;
    logic [3:0]    op;
    logic [1:0]    eh, el;
    bit            z, wr;
    exp_fetch.delete(); exp_out.delete(); m_halted = 0;
    for (int i = 0; i < 4; i++) r[i] = '0;
    z = 0; pc = '0;
    for (int n = 0; n < max_instr && !m_halted; n++) begin
      {op, eh, el, k} = imem[pc];
      exp_fetch.push_back(pc);
      a = el[1] ? r[1] : r[0];
      b = el[0] ? DW'(k) : r[2];
      res = '0; wr = 0;
      pc = pc + 8'd1;
      case (op)
        4'd0: begin res = a + b; wr = 1; end
        4'd1: begin res = a - b; wr = 1; end
        4'd2: begin res = a & b; wr = 1; end
        4'd3: begin res = a | b; wr = 1; end
        4'd4: begin res = a ^ b; wr = 1; end
        4'd5: begin
          amt = el[1] ? DW'(k) : r[3];
          res = (amt >= DW) ? '0 : (el[0] ? (r[eh] >> amt) : (r[eh] << amt));
          wr = 1;
        end
        4'd6:  r[eh] = mdm[k];
        4'd7:  mdm[k] = r[eh];
        4'd8:  begin res = r[el]; wr = 1; end
        4'd9:  pc = r[0][7:0];
`ifdef CR_CORE_ZFLAG_EN
        4'd12: if (z) pc = r[0][7:0];
`endif
        4'd10: r[eh] = DW'(k);
        4'd11: exp_out.push_back(r[eh]);
        4'd13: r[eh][15:8] = k;
        4'd14: m_halted = 1;
        default: ;
      endcase
      if (wr) begin r[eh] = res; z = (res == '0); end
    end
  endtask

  task automatic prog_clear();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic start_dut();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_imem_req", o_imem_req, 0);
    check("rst_pc", o_imem_addr, 0);
    check("rst_dmem_req", o_dmem_req, 0);
    check("rst_dmem_we", o_dmem_we, 0);
    check("rst_out", o_out, 0);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_halted", o_halted, 0);
    got_fetch.delete(); got_out.delete();
    i_reset = 1'b0;
  endtask

  task automatic run_to_halt(input int fetch_limit, input int budget, output int fr, output int fv);
    bit done;
    done = 0; fr = -1; fv = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (o_imem_req && fr < 0) fr = c;
      if (o_out_valid) begin
        if (fv < 0) fv = c;
        got_out.push_back(o_out);
      end
      if (o_halted || got_fetch.size() >= fetch_limit) done = 1;
    end
    check("run_within_budget", done, 1);
  endtask

  task automatic compare(input string tag, input int nf);
    int bad;
    check({tag, ":n_out"}, got_out.size(), exp_out.size());
    for (int i = 0; i < exp_out.size(); i++)
      check($sformatf("%s:out%0d", tag, i), out_at(i), exp_out[i]);
    if (nf == 0) check({tag, ":n_fetch"}, got_fetch.size(), exp_fetch.size());
    for (int i = 0; i < exp_fetch.size(); i++)
      check($sformatf("%s:fetch%0d", tag, i), fetch_at(i), exp_fetch[i]);
    check({tag, ":halted"}, o_halted, m_halted);
    bad = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== mdm[i]) bad++;
    check({tag, ":dmem_diffs"}, bad, 0);
  endtask

  task automatic run_program(input string tag, input int nf, output int fr, output int fv);
    for (int i = 0; i < 256; i++) mdm[i] = dmem[i];
    run_model(nf == 0 ? 500 : nf);
    start_dut();
    run_to_halt(nf == 0 ? 100000 : nf, 3000, fr, fv);
    compare(tag, nf);
  endtask

  task automatic gen_random();
    int         pc, op;
    int         ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 13};
    logic [1:0] el;
    logic [7:0] k;
    prog_clear();
    pc = 0;
    for (int r = 0; r < 4; r++) begin
      imem[pc] = enc(10, r, 0, $urandom_range(255, 0)); pc++;
      imem[pc] = enc(13, r, 0, $urandom_range(255, 0)); pc++;
    end
    for (int n = 0; n < 20; n++) begin
      op = ops[$urandom_range(11, 0)];
      el = 2'($urandom_range(3, 0));
      k  = 8'($urandom_range(255, 0));
      if (op == 5 && el[1]) k = 8'($urandom_range(40, 0));
      imem[pc] = enc(op, $urandom_range(3, 0), int'(el), int'(k)); pc++;
      if ($urandom_range(1, 0) == 1) begin
        imem[pc] = enc(11, $urandom_range(3, 0), 0, 0); pc++;
      end
    end
    for (int r = 0; r < 4; r++) begin
      imem[pc] = enc(11, r, 0, 0); pc++;
    end
    imem[pc] = enc(14, 0, 0, 0);
  endtask

  initial begin
    int         fr, fv, c;
    bit         any;
    logic [31:0] v;
    for (int i = 0; i < 256; i++) dmem[i] = $urandom;

    // Program A, zero-wait: ra=5, rc=3, rd=ra+rc, OUT rd.
    prog_clear();
    imem[0] = enc(10, 0, 0, 5);
    imem[1] = enc(10, 2, 0, 3);
    imem[2] = enc(0, 3, 0, 0);
    imem[3] = enc(11, 3, 0, 0);
    imem[4] = enc(14, 0, 0, 0);
    maxd = 0; noise = 0;
    run_program("progA", 0, fr, fv);
    check("progA_out_is_8", out_at(0), 8);
    check("first_req_cycle_after_release", fr, 0);
    check("out_valid_8_cycles_after_first_req", fv - fr, 8);
    any = 0;
    repeat (4) begin
      @(negedge clk);
      any |= o_imem_req | o_dmem_req;
    end
    check("halt_no_further_req", any, 0);
    check("halt_stays_high", o_halted, 1);

    // STORE rb -> 0x10, LOAD rc <- 0x10 under random wait states and spurious acks.
    maxd = 3; noise = 1;
    for (int t = 0; t < 3; t++) begin
      v = $urandom;
      prog_clear();
      imem[0] = enc(10, 1, 0, int'(v[7:0]));
      imem[1] = enc(13, 1, 0, int'(v[15:8]));
      imem[2] = enc(7, 1, 0, 8'h10);
      imem[3] = enc(6, 2, 0, 8'h10);
      imem[4] = enc(11, 2, 0, 0);
      imem[5] = enc(14, 0, 0, 0);
      run_program($sformatf("stld%0d", t), 0, fr, fv);
      check("stld_rc_equals_rb", out_at(0), {16'h0, v[15:0]});
      check("stld_dmem_0x10", dmem[8'h10], {16'h0, v[15:0]});
    end

    // LOADCH keeps other bits; shifts by >= width give 0; right shift by rd.
    maxd = 0; noise = 0;
    prog_clear();
    imem[0] = enc(10, 0, 0, 8'h34);
    imem[1] = enc(13, 0, 0, 8'h12);
    imem[2] = enc(11, 0, 0, 0);
    imem[3] = enc(10, 1, 0, 1);
    imem[4] = enc(5, 1, 2, 40);
    imem[5] = enc(11, 1, 0, 0);
    imem[6] = enc(10, 3, 0, 4);
    imem[7] = enc(10, 1, 0, 8'h80);
    imem[8] = enc(5, 1, 1, 0);
    imem[9] = enc(11, 1, 0, 0);
    imem[10] = enc(14, 0, 0, 0);
    run_program("shift", 0, fr, fv);
    check("loadch_result", out_at(0), 32'h0000_1234);
    check("shift_by_40_zero", out_at(1), 0);
    check("shift_right_by_rd", out_at(2), 8);

    // JUMPZ after SUB yielding zero (k=7) and nonzero (k=6).
    for (int t = 0; t < 2; t++) begin
      prog_clear();
      imem[0] = enc(10, 0, 0, 8'h20);
      imem[1] = enc(10, 1, 0, 7);
      imem[2] = enc(1, 1, 3, 7 - t);
      imem[3] = enc(12, 0, 0, 0);
      imem[4] = enc(11, 1, 0, 0);
      imem[5] = enc(14, 0, 0, 0);
      imem[8'h20] = enc(11, 0, 0, 0);
      imem[8'h21] = enc(14, 0, 0, 0);
      run_program($sformatf("jumpz%0d", t), 0, fr, fv);
`ifdef CR_CORE_ZFLAG_EN
      check("jumpz_target", fetch_at(4), (t == 0) ? 8'h20 : 8'h04);
`else
      check("jumpz_as_nop", fetch_at(4), 8'h04);
`endif
    end

    // PC wrap: JUMP to 0xFF, NOP there, next fetch is 0x00.
    prog_clear();
    imem[0] = enc(10, 0, 0, 8'hFF);
    imem[1] = enc(9, 0, 0, 0);
    run_program("wrap", 6, fr, fv);
    check("wrap_fetch_ff", fetch_at(2), 8'hFF);
    check("wrap_fetch_00", fetch_at(3), 8'h00);

    // Reset while a fetch waits, with an ack arriving in the reset cycle.
    prog_clear();
    imem[0] = enc(10, 0, 0, 5);
    imem[3] = enc(11, 0, 0, 0);
    imem[4] = enc(14, 0, 0, 0);
    for (int i = 0; i < 256; i++) mdm[i] = dmem[i];
    run_model(500);
    start_dut();
    c = 0;
    while (got_fetch.size() < 2 && c < 50) begin @(negedge clk); c++; end
    iblock = 1;
    c = 0;
    while (!(o_imem_req && o_imem_addr == 8'd2) && c < 50) begin @(negedge clk); c++; end
    check("rst_mid_fetch_waiting", {o_imem_req, o_imem_addr}, {1'b1, 8'd2});
    @(posedge clk); #1;
    i_reset = 1'b1; force_iack = 1;
    @(posedge clk); #1;
    i_reset = 1'b0; force_iack = 0;
    check("rst_mid_req_low", o_imem_req, 0);
    check("rst_mid_pc0", o_imem_addr, 0);
    check("rst_mid_out_valid", o_out_valid, 0);
    got_fetch.delete(); got_out.delete();
    iblock = 0;
    @(posedge clk); #1;
    check("rst_mid_restart_req", o_imem_req, 1);
    check("rst_mid_restart_addr", o_imem_addr, 0);
    run_to_halt(100000, 500, fr, fv);
    compare("rst_mid", 0);

    // Random programs under random wait states.
    noise = 1;
    for (int t = 0; t < 6; t++) begin
      maxd = $urandom_range(3, 0);
      gen_random();
      run_program($sformatf("rand%0d", t), 0, fr, fv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cr_core.md
# cr_core

Parametrised successor to the single-cycle-RAM CPU core. It is a multi-cycle 4-register CPU with 16-bit instructions. Instruction and data memories sit outside the core and are reached through req/ack handshake ports, so wait-stated block RAM or shared buses can back them. It adds a configurable data width, a zero flag with conditional jump, an upper-byte constant load, a strobed output port and a halt indication. It is the top-level execution block of the design.

## Interface
- `DATA_WIDTH`, 16 — register/ALU/data-bus width; must be ≥16.
- `INST_ADDR_WIDTH`, 8 — PC and instruction-address width.
- `DATA_ADDR_WIDTH`, 8 — data-address width; must be ≤8 (address is the constant field, zero-extended).
- `i_clk` in 1 — the single clock; all logic on rising edge.
- `i_reset` in 1 — reset, synchronous, active-high.
- `o_imem_req` out 1 — instruction fetch request.
- `o_imem_addr` out INST_ADDR_WIDTH — fetch address (PC).
- `i_imem_ack` in 1 — fetch complete; `i_imem_data` valid this cycle.
- `i_imem_data` in 16 — instruction word.
- `o_dmem_req` out 1 — data access request.
- `o_dmem_we` out 1 — 1 = store, 0 = load.
- `o_dmem_addr` out DATA_ADDR_WIDTH — data address.
- `o_dmem_wdata` out DATA_WIDTH — store data.
- `i_dmem_ack` in 1 — access complete; `i_dmem_rdata` valid this cycle for loads.
- `i_dmem_rdata` in DATA_WIDTH — load data.
- `o_out` out DATA_WIDTH — output register.
- `o_out_valid` out 1 — one-cycle strobe when `o_out` is updated.
- `o_halted` out 1 — high while in HALTED.

## Operation
- Fields: opcode `[15:12]`, eh `[11:10]`, el `[9:8]`, k `[7:0]`. Registers ra..rd are indexed 0..3.
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SHIFT 5, LOAD 6, STORE 7, MOVE 8, JUMP 9, LOADC 10, OUT 11, JUMPZ 12, LOADCH 13, HALT 14, NOP 15.
- ADD/SUB/AND/OR/XOR: `reg[eh] = A op B`.
  - A = el[1] ? rb : ra.
  - B = el[0] ? zext(k) : rc.
  - ADD/SUB wrap modulo 2^DATA_WIDTH; no carry is kept.
- SHIFT: `reg[eh] = reg[eh]` shifted left (el[0]=0) or logically right (el[0]=1).
  - Amount = el[1] ? k : rd.
  - Any amount ≥ DATA_WIDTH gives 0.
- MOVE: `reg[eh] = reg[el]`.
- LOADC: `reg[eh] = zext(k)`.
- LOADCH: `reg[eh][15:8] = k`; all other bits are kept.
- LOAD: `reg[eh] = dmem[k]`.
- STORE: `dmem[k] = reg[eh]`.
- JUMP: PC = ra[INST_ADDR_WIDTH-1:0].
- JUMPZ: if Z, PC = ra[INST_ADDR_WIDTH-1:0]; otherwise PC+1.
- OUT: `o_out = reg[eh]`, and `o_out_valid` pulses.
- HALT: enter HALTED. NOP: PC+1 only.
- Zero flag Z is set to (result == 0) on ADD..SHIFT and MOVE. It is unchanged by all other opcodes.
- PC increments modulo 2^INST_ADDR_WIDTH. Incrementing from all-ones wraps to 0.
- State machine:
  - FETCH: req asserted until ack; the instruction is latched on ack; next state EXECUTE.
  - EXECUTE: register/flag/PC/output updates; LOAD/STORE → MEM, HALT → HALTED, all others → FETCH.
  - MEM: dmem req held until ack; LOAD writes back on ack; PC+1; next state FETCH.
  - HALTED: terminal until reset.

## Timing
- Reset values:
  - state FETCH, PC 0, ra..rd 0, Z 0.
  - `o_out` 0, `o_out_valid` 0.
  - all req/we 0, `o_halted` 0.
- Outputs are registered; the first fetch req appears the cycle after reset deasserts.
- Handshake:
  - Once asserted, req stays high and address/we/wdata stay stable until the cycle ack is sampled high.
  - req drops the following cycle.
  - ack while req is low is ignored.
  - Zero-wait memory (ack in the first req cycle) is legal.
- Minimum latency with zero-wait memories: 2 cycles per non-memory instruction, 3 cycles per LOAD/STORE.
- Each extra wait cycle adds exactly 1 cycle.
- A register written in EXECUTE is visible to the next instruction.
- `o_out_valid` is high for exactly the one cycle after OUT's EXECUTE.
- Reset asserted mid-fetch or mid-MEM:
  - the next edge applies reset values and abandons the access;
  - an ack seen in the reset cycle has no effect.

## Configuration
- `CR_CORE_ZFLAG_EN` defined: Z flag and JUMPZ are implemented as above.
- Undefined: no Z register; JUMPZ executes as NOP (PC+1).

## Structure
- Package `cr_core_pkg`: opcode constants, state encoding, field bit positions.
- One sub-module, `cr_alu`: combinational, parametrised by DATA_WIDTH; inputs opcode, A, B, shift direction; outputs result and zero.

## Test plan
- Zero-wait memories: LOADC ra,5; LOADC rc,3; ADD rd(ra+rc); OUT rd → `o_out`=8 with a one-cycle valid, 8 cycles after reset release.
- Random 0–3 cycle ack delays on both ports, running a STORE rb→addr 0x10 then LOAD rc←0x10 → rc equals rb; req/addr/wdata stable while waiting.
- LOADC ra,0x34; LOADCH ra,0x12 with DATA_WIDTH=32 → ra=0x00001234. SHIFT left by k=40 → 0.
- SUB giving 0, then JUMPZ to ra=0x20 → next fetch addr 0x20. With the macro undefined → fetch addr PC+1.
- PC at 0xFF executing NOP → next fetch addr 0x00. HALT → `o_halted`=1, no further req.
- Reset pulsed while `o_imem_req` is waiting → req low and PC 0 next cycle, then a fetch restarts at 0.
